dmem_bridge: RTL and testbench

- Downstream neighbour of the MEM stage.
- Turns MEM's load/store (address, byte selects, size, aligned write data) into one SRAM-like split-transaction request on the data bus: req / addr_ok / data_ok.
- Returns raw read data to MEM's load-extension path (mem_rdata).
- Stalls the pipeline until the access completes, and drains accesses killed by a flush.

---
 rtl/dmem_bridge_pkg.sv | 20 ++
 rtl/dmem_addr_map.sv | 30 +++
 rtl/dmem_bridge.sv | 163 ++++++++++++++++
 tb/tb_dmem_bridge.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge between MEM and the SRAM-like data bus.
// Optional kseg translation is enabled with DMEM_KSEG_MAP_EN (see dmem_addr_map).
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dmem_state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Top three address bits identifying the unmapped kernel segments.
    localparam logic [2:0] KSEG0_HI = 3'b100;
    localparam logic [2:0] KSEG1_HI = 3'b101;

endpackage

// File: rtl/dmem_addr_map.sv
// Virtual-to-bus address mapping and uncached attribute for data accesses.
// With DMEM_KSEG_MAP_EN defined kseg0/kseg1 fold to physical low memory; otherwise pass-through.
module dmem_addr_map
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] vaddr_i,
    input  logic              kseg0_uncached_i,
    output logic [ADDR_W-1:0] paddr_o,
    output logic              uncached_o
);

`ifdef DMEM_KSEG_MAP_EN
    logic is_kseg0;
    logic is_kseg1;

    assign is_kseg0   = (vaddr_i[ADDR_W-1 -: 3] == KSEG0_HI);
    assign is_kseg1   = (vaddr_i[ADDR_W-1 -: 3] == KSEG1_HI);
    assign paddr_o    = (is_kseg0 | is_kseg1) ? {3'b000, vaddr_i[ADDR_W-4:0]} : vaddr_i;
    assign uncached_o = is_kseg1 | (is_kseg0 & kseg0_uncached_i);
`else
    logic unused_kseg0_uncached;

    assign paddr_o               = vaddr_i;
    assign uncached_o            = 1'b0;
    assign unused_kseg0_uncached = kseg0_uncached_i;
`endif

endmodule

// File: rtl/dmem_bridge.sv
// Converts one MEM-stage load/store into a split req/addr_ok/data_ok bus transaction,
// stalls the pipeline until it completes, and drains transactions killed by a flush.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_rmem,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_size,
    input  logic [3:0]        mem_sel,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_exc,
    input  logic              mem_advance,
    input  logic              flush,
    input  logic              kseg0_uncached,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [3:0]        data_wstrb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    output logic              data_uncached,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              dmem_stall,
    output dmem_state_t       dbg_state
);

    // Bus handshake: data_req is held with stable fields until the cycle data_addr_ok is
    // seen (the request is accepted in that cycle and never withdrawn); data_data_ok marks
    // the response and may coincide with data_addr_ok. data_data_ok before acceptance is ignored.

    dmem_state_t       state_q, state_d;
    logic              killed_q, killed_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              unc_q, unc_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              new_req;
    logic              kill;
    logic [ADDR_W-1:0] map_addr;
    logic              map_unc;

    dmem_addr_map #(.ADDR_W(ADDR_W)) u_addr_map (
        .vaddr_i          (mem_addr),
        .kseg0_uncached_i (kseg0_uncached),
        .paddr_o          (map_addr),
        .uncached_o       (map_unc)
    );

    assign new_req = mem_valid & (mem_rmem | mem_we) & ~mem_exc & ~flush;
    assign kill    = killed_q | flush;

    always_comb begin
        state_d  = state_q;
        killed_d = killed_q;
        wr_d     = wr_q;
        size_d   = size_q;
        wstrb_d  = wstrb_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        unc_d    = unc_q;
        rdata_d  = rdata_q;

        case (state_q)
            IDLE: begin
                killed_d = 1'b0;
                if (new_req) begin
                    state_d = REQ;
                    wr_d    = mem_we;
                    size_d  = mem_size;
                    wstrb_d = mem_we ? mem_sel : 4'b0000;
                    addr_d  = map_addr;
                    wdata_d = mem_wdata;
                    unc_d   = map_unc;
                end
            end
            REQ: begin
                if (flush) killed_d = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        if (kill) begin
                            state_d  = IDLE;
                            killed_d = 1'b0;
                        end else begin
                            state_d = DONE;
                            if (!wr_q) rdata_d = data_rdata;
                        end
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (flush) killed_d = 1'b1;
                if (data_data_ok) begin
                    // A killed access drains without touching the load result.
                    if (kill) begin
                        state_d  = IDLE;
                        killed_d = 1'b0;
                    end else begin
                        state_d = DONE;
                        if (!wr_q) rdata_d = data_rdata;
                    end
                end
            end
            DONE: begin
                if (mem_advance | flush) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            killed_q <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            wstrb_q  <= 4'b0000;
            addr_q   <= '0;
            wdata_q  <= '0;
            unc_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            killed_q <= killed_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            wstrb_q  <= wstrb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            unc_q    <= unc_d;
            rdata_q  <= rdata_d;
        end
    end

    assign data_req      = (state_q == REQ);
    assign data_wr       = data_req & wr_q;
    assign data_size     = data_req ? size_q  : 2'd0;
    assign data_wstrb    = data_req ? wstrb_q : 4'b0000;
    assign data_addr     = data_req ? addr_q  : '0;
    assign data_wdata    = data_req ? wdata_q : '0;
    assign data_uncached = data_req & unc_q;
    assign mem_rdata     = rdata_q;
    assign dbg_state     = state_q;

    // Stall is combinational so the issuing instruction is frozen from its first MEM cycle.
    assign dmem_stall = ~rst & (((state_q == IDLE) & new_req) | (state_q == REQ) | (state_q == WAIT));

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge: loads, stores, flush drain, exception
// suppression, back-to-back accesses and reset mid-transaction.
module tb_dmem_bridge;
    import dmem_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0, mem_rmem = 1'b0, mem_we = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [1:0]  mem_size = '0;
    logic [3:0]  mem_sel = '0;
    logic        mem_exc = 1'b0, mem_advance = 1'b0, flush = 1'b0, kseg0_uncached = 1'b1;
    logic        data_req, data_wr, data_uncached;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, mem_rdata;
    logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
    logic [31:0] data_rdata = '0;
    logic        dmem_stall;
    dmem_state_t dbg_state;

    dmem_bridge dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_rmem(mem_rmem), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_size(mem_size), .mem_sel(mem_sel), .mem_wdata(mem_wdata),
        .mem_exc(mem_exc), .mem_advance(mem_advance), .flush(flush),
        .kseg0_uncached(kseg0_uncached), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_uncached(data_uncached), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .mem_rdata(mem_rdata),
        .dmem_stall(dmem_stall), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

`ifdef DMEM_KSEG_MAP_EN
    localparam logic [31:0] EXP_A_LW = 32'h0000_0104;
    localparam logic [31:0] EXP_A_SB = 32'h0000_0003;
    localparam logic        EXP_U_LW = 1'b1;
    localparam logic        EXP_U_SB = 1'b1;
`else
    localparam logic [31:0] EXP_A_LW = 32'h8000_0104;
    localparam logic [31:0] EXP_A_SB = 32'hA000_0003;
    localparam logic        EXP_U_LW = 1'b0;
    localparam logic        EXP_U_SB = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic check_rdata(input string tag);
        logic [31:0] e;
        e = exp_q.pop_front();
        check(tag, mem_rdata, e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slave model: accepts after sl_acc_wait REQ cycles, responds sl_rsp_wait cycles later.
    int          sl_acc_wait, sl_rsp_wait, sl_cnt;
    bit          sl_pending;
    logic [31:0] sl_rdata;

    task automatic slave_drive();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        if (sl_pending) begin
            sl_cnt++;
            if (sl_cnt >= sl_rsp_wait) begin
                data_data_ok = 1'b1;
                data_rdata   = sl_rdata;
                sl_pending   = 1'b0;
                sl_cnt       = 0;
            end
        end else if (data_req) begin
            if (sl_cnt >= sl_acc_wait) begin
                data_addr_ok = 1'b1;
                sl_cnt       = 0;
                if (sl_rsp_wait == 0) begin
                    data_data_ok = 1'b1;
                    data_rdata   = sl_rdata;
                end else begin
                    sl_pending = 1'b1;
                end
            end else begin
                sl_cnt++;
            end
        end
    endtask

    int          n_stall, n_req_cycles, n_req_starts, n_dok, tail_req;
    bit          fin, stable;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_size;
    logic        s_wr, s_unc;

    // Drives one MEM instruction until it leaves MEM; fl >= 0 pulses flush fl cycles after acceptance.
    task automatic do_access(input logic ld, input logic [31:0] addr, input logic [1:0] size,
                             input logic [3:0] sel, input logic [31:0] wdata, input logic exc,
                             input int aw, input int rw, input logic [31:0] rd, input int fl);
        int   acc_age;
        logic prev_req;
        sl_acc_wait = aw; sl_rsp_wait = rw; sl_rdata = rd; sl_pending = 1'b0; sl_cnt = 0;
        n_stall = 0; n_req_cycles = 0; n_req_starts = 0; n_dok = 0;
        fin = 1'b0; stable = 1'b1; acc_age = -1; prev_req = 1'b0;
        mem_valid = 1'b1; mem_rmem = ld; mem_we = ~ld; mem_addr = addr; mem_size = size;
        mem_sel = sel; mem_wdata = wdata; mem_exc = exc;
        for (int c = 0; c < 30 && !fin; c++) begin
            flush = (fl >= 0) && (acc_age == fl);
            if (flush) mem_valid = 1'b0;
            slave_drive();
            #1;
            if (dmem_stall) n_stall++;
            if (data_req) begin
                n_req_cycles++;
                if (!prev_req) begin
                    n_req_starts++;
                    s_addr = data_addr; s_wdata = data_wdata; s_wstrb = data_wstrb;
                    s_size = data_size; s_wr = data_wr; s_unc = data_uncached;
                end else if (s_addr !== data_addr || s_wdata !== data_wdata ||
                             s_wstrb !== data_wstrb || s_size !== data_size || s_wr !== data_wr) begin
                    stable = 1'b0;
                end
            end
            prev_req = data_req;
            if (data_data_ok) n_dok++;
            if (data_addr_ok) acc_age = 0;
            else if (acc_age >= 0) acc_age++;
            if (!dmem_stall) begin
                mem_advance = mem_valid;
                fin = 1'b1;
            end
            tick();
            mem_advance = 1'b0;
            flush = 1'b0;
        end
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        mem_valid = 1'b0; mem_rmem = 1'b0; mem_we = 1'b0; mem_exc = 1'b0;
        check("access_finished", {31'd0, fin}, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        tail_req = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            if (data_req) tail_req++;
            tick();
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
        check("rst_req", {31'd0, data_req}, 32'd0);
        check("rst_stall", {31'd0, dmem_stall}, 32'd0);
        check("rst_rdata", mem_rdata, 32'h0);
        tick();

        // LW through kseg0, slave accepts on the second REQ cycle and responds one later
        exp_q.push_back(32'hDEAD_BEEF);
        do_access(1'b1, 32'h8000_0104, SIZE_W, 4'b1111, 32'h0, 1'b0, 1, 1, 32'hDEAD_BEEF, -1);
        check("lw_stall_cycles", n_stall, 32'd4);
        check("lw_req_cycles", n_req_cycles, 32'd2);
        check("lw_addr", s_addr, EXP_A_LW);
        check("lw_uncached", {31'd0, s_unc}, {31'd0, EXP_U_LW});
        check("lw_wr", {31'd0, s_wr}, 32'd0);
        check("lw_wstrb", {28'd0, s_wstrb}, 32'd0);
        check("lw_size", {30'd0, s_size}, {30'd0, SIZE_W});
        check("lw_stable", {31'd0, stable}, 32'd1);
        check_rdata("lw_rdata");

        // SB through kseg1, zero-wait slave
        exp_q.push_back(32'hDEAD_BEEF);
        do_access(1'b0, 32'hA000_0003, SIZE_B, 4'b1000, 32'h5500_0000, 1'b0, 0, 0, 32'hFFFF_FFFF, -1);
        check("sb_stall_cycles", n_stall, 32'd2);
        check("sb_req_cycles", n_req_cycles, 32'd1);
        check("sb_wr", {31'd0, s_wr}, 32'd1);
        check("sb_wstrb", {28'd0, s_wstrb}, 32'h8);
        check("sb_size", {30'd0, s_size}, {30'd0, SIZE_B});
        check("sb_addr", s_addr, EXP_A_SB);
        check("sb_wdata", s_wdata, 32'h5500_0000);
        check("sb_uncached", {31'd0, s_unc}, {31'd0, EXP_U_SB});
        check_rdata("sb_rdata_kept");

        // Flush one cycle after acceptance; response three cycles after acceptance
        exp_q.push_back(32'hDEAD_BEEF);
        do_access(1'b1, 32'h0000_0040, SIZE_W, 4'b1111, 32'h0, 1'b0, 0, 3, 32'h1234_5678, 0);
        check("flush_stall_cycles", n_stall, 32'd5);
        check("flush_req_starts", n_req_starts, 32'd1);
        check("flush_data_ok", n_dok, 32'd1);
        check_rdata("flush_rdata_kept");
        idle_cycles(3);
        check("flush_no_extra_req", tail_req, 32'd0);
        check("flush_state_idle", {30'd0, dbg_state}, {30'd0, IDLE});

        // Excepting load must not reach the bus
        do_access(1'b1, 32'h0000_0080, SIZE_W, 4'b1111, 32'h0, 1'b1, 0, 0, 32'h0BAD_0BAD, -1);
        check("exc_stall_cycles", n_stall, 32'd0);
        check("exc_req_cycles", n_req_cycles, 32'd0);
        idle_cycles(3);
        check("exc_no_late_req", tail_req, 32'd0);

        // Back-to-back LW then SW with mem_advance between them
        exp_q.push_back(32'hCAFE_F00D);
        do_access(1'b1, 32'h0000_0200, SIZE_W, 4'b1111, 32'h0, 1'b0, 0, 0, 32'hCAFE_F00D, -1);
        check("b2b_lw_req_cycles", n_req_cycles, 32'd1);
        check("b2b_lw_stall", n_stall, 32'd2);
        check("b2b_lw_addr", s_addr, 32'h0000_0200);
        check_rdata("b2b_lw_rdata");
        exp_q.push_back(32'hCAFE_F00D);
        do_access(1'b0, 32'h0000_0204, SIZE_W, 4'b1111, 32'h0BAD_F00D, 1'b0, 0, 0, 32'h0, -1);
        check("b2b_sw_req_cycles", n_req_cycles, 32'd1);
        check("b2b_sw_stall", n_stall, 32'd2);
        check("b2b_sw_addr", s_addr, 32'h0000_0204);
        check("b2b_sw_wdata", s_wdata, 32'h0BAD_F00D);
        check("b2b_sw_wstrb", {28'd0, s_wstrb}, 32'hF);
        check_rdata("b2b_sw_rdata_kept");
        idle_cycles(2);
        check("b2b_no_extra_req", tail_req, 32'd0);

        // Reset while the request is outstanding in REQ
        sl_pending = 1'b0;
        mem_valid = 1'b1; mem_rmem = 1'b1; mem_we = 1'b0; mem_addr = 32'h8000_0104;
        mem_size = SIZE_W; mem_sel = 4'b1111; mem_wdata = 32'h0;
        #1;
        check("rreq_idle_stall", {31'd0, dmem_stall}, 32'd1);
        tick();
        check("rreq_in_req", {31'd0, data_req}, 32'd1);
        rst = 1'b1;
        tick();
        check("rreq_req_cleared", {31'd0, data_req}, 32'd0);
        check("rreq_addr_cleared", data_addr, 32'h0);
        check("rreq_stall_cleared", {31'd0, dmem_stall}, 32'd0);
        check("rreq_rdata_cleared", mem_rdata, 32'h0);
        check("rreq_state", {30'd0, dbg_state}, {30'd0, IDLE});
        rst = 1'b0;
        mem_valid = 1'b0; mem_rmem = 1'b0;
        tick();
        check("rreq_idle_after", {31'd0, data_req}, 32'd0);

        exp_q.push_back(32'hDEAD_BEEF);
        do_access(1'b1, 32'h8000_0104, SIZE_W, 4'b1111, 32'h0, 1'b0, 1, 1, 32'hDEAD_BEEF, -1);
        check("post_rst_stall", n_stall, 32'd4);
        check("post_rst_addr", s_addr, EXP_A_LW);
        check("post_rst_req_starts", n_req_starts, 32'd1);
        check_rdata("post_rst_rdata");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
